// File: rtl/seg_display_scan_if.sv
// Display-side bundle for the 4-digit scanner: BCD pairs and controls in, pin drives out.
interface seg_display_scan_if;
    logic [7:0] bcd_minutes;
    logic [7:0] bcd_hours;
    logic [7:0] alarm_bcd_minutes;
    logic [7:0] alarm_bcd_hours;
    logic       show_alarm;
    logic       display_en;
    logic       blink_minutes;
    logic       blink_hours;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    modport master (
        output bcd_minutes, bcd_hours, alarm_bcd_minutes, alarm_bcd_hours,
        output show_alarm, display_en, blink_minutes, blink_hours,
        input  an, seg, dp
    );

    modport slave (
        input  bcd_minutes, bcd_hours, alarm_bcd_minutes, alarm_bcd_hours,
        input  show_alarm, display_en, blink_minutes, blink_hours,
        output an, seg, dp
    );
endinterface

// File: rtl/seg_display_scan.sv
// Time-multiplexed 4-digit common-anode 7-segment scanner with snapshot, blanking and blink.
// Optional SEG_COLON_BLINK_EN drives dp as a blinking colon on the idx2 digit.
module seg_display_scan #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 50000000
) (
    input  logic               clk,
    input  logic               reset,
    seg_display_scan_if.slave  bus
);
    localparam int DIV_W   = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int BLINK_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

    logic [DIV_W-1:0]   r_div_cnt;
    logic [1:0]         r_digit_idx;
    logic [BLINK_W-1:0] r_blink_cnt;
    logic               r_blink_ph;
    logic [15:0]        r_shadow;
    logic [3:0]         r_an;
    logic [6:0]         r_seg;

    logic               w_div_tc;
    logic               w_blink_tc;
    logic [3:0]         w_nibble;
    logic               w_blank;
    logic [6:0]         w_seg;
    logic [3:0]         w_an;
    logic               w_gate;

    assign w_div_tc   = (r_div_cnt == DIV_W'(REFRESH_DIV - 1));
    assign w_blink_tc = (r_blink_cnt == BLINK_W'(BLINK_DIV - 1));
    // Anodes dark on the first cycle of every slot so the previous digit's segments never ghost.
    assign w_gate     = (r_div_cnt == '0) || !bus.display_en;

    always_comb begin
        w_nibble = r_shadow[3:0];
        case (r_digit_idx)
            2'd0: w_nibble = r_shadow[3:0];
            2'd1: w_nibble = r_shadow[7:4];
            2'd2: w_nibble = r_shadow[11:8];
            2'd3: w_nibble = r_shadow[15:12];
            default: w_nibble = r_shadow[3:0];
        endcase
    end

    always_comb begin
        w_blank = 1'b0;
        if (r_digit_idx == 2'd3 && w_nibble == 4'd0)
            w_blank = 1'b1;
        if (r_blink_ph && bus.blink_minutes && !r_digit_idx[1])
            w_blank = 1'b1;
        if (r_blink_ph && bus.blink_hours && r_digit_idx[1])
            w_blank = 1'b1;
    end

    always_comb begin
        w_seg = 7'b0111111;
        case (w_nibble)
            4'd0: w_seg = 7'b1000000;
            4'd1: w_seg = 7'b1111001;
            4'd2: w_seg = 7'b0100100;
            4'd3: w_seg = 7'b0110000;
            4'd4: w_seg = 7'b0011001;
            4'd5: w_seg = 7'b0010010;
            4'd6: w_seg = 7'b0000010;
            4'd7: w_seg = 7'b1111000;
            4'd8: w_seg = 7'b0000000;
            4'd9: w_seg = 7'b0010000;
            default: w_seg = 7'b0111111;
        endcase
        if (w_blank)
            w_seg = 7'b1111111;
    end

    always_comb begin
        w_an = 4'b1111;
        if (!w_gate)
            w_an = ~(4'b0001 << r_digit_idx);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_div_cnt   <= '0;
            r_digit_idx <= 2'd0;
            r_blink_cnt <= '0;
            r_blink_ph  <= 1'b0;
            r_shadow    <= 16'h0000;
            r_an        <= 4'b1111;
            r_seg       <= 7'b1111111;
        end else begin
            if (w_div_tc) begin
                r_div_cnt   <= '0;
                r_digit_idx <= r_digit_idx + 2'd1;
                // Snapshot only between scans so a frame never mixes old and new digits.
                if (r_digit_idx == 2'd3)
                    r_shadow <= bus.show_alarm ? {bus.alarm_bcd_hours, bus.alarm_bcd_minutes}
                                               : {bus.bcd_hours, bus.bcd_minutes};
            end else begin
                r_div_cnt <= r_div_cnt + DIV_W'(1);
            end

            if (w_blink_tc) begin
                r_blink_cnt <= '0;
                r_blink_ph  <= ~r_blink_ph;
            end else begin
                r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
            end

            r_an  <= w_an;
            r_seg <= w_seg;
        end
    end

    assign bus.an  = r_an;
    assign bus.seg = r_seg;

`ifdef SEG_COLON_BLINK_EN
    logic r_dp;
    always_ff @(posedge clk) begin
        if (reset)
            r_dp <= 1'b1;
        else
            r_dp <= ~((r_digit_idx == 2'd2) && !r_blink_ph && !w_gate);
    end
    assign bus.dp = r_dp;
`else
    assign bus.dp = 1'b1;
`endif
endmodule
